// File: rtl/sort_sequencer_if.sv
// Stream-in / stream-out bundle for the sequenced 8-entry sorter.
// The master drives the load and drain handshakes, and the slave is the sorter.
interface sort_sequencer_if #(
    parameter int unsigned DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/sort_sequencer.sv
// Time-multiplexed 8-entry sorter with one shared compare-exchange unit.
// It runs the 19-step Batcher odd-even merge network and then streams the words out largest first.
module sort_sequencer #(
    parameter int unsigned DATA_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    sort_sequencer_if.slave bus
);
    localparam int unsigned N      = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned STEPS  = 19;
    localparam int unsigned STEP_W = 5;

    typedef enum logic [1:0] {
        S_LOAD,
        S_SORT,
        S_DRAIN
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DATA_W-1:0]  regs [N];
    logic [IDX_W-1:0]   wr_cnt;
    logic [IDX_W-1:0]   rd_cnt;
    logic [STEP_W-1:0]  step;
    logic [IDX_W-1:0]   ci;
    logic [IDX_W-1:0]   cj;
    logic               accept;
    logic               emit;
    logic               swap;
    logic               sort_done;

    // Schedule ROM: the compare pair (i,j), i<j, used at each sort step
    always_comb begin
        ci = '0;
        cj = '0;
        case (step)
            5'd0:    begin ci = 3'd0; cj = 3'd1; end
            5'd1:    begin ci = 3'd2; cj = 3'd3; end
            5'd2:    begin ci = 3'd4; cj = 3'd5; end
            5'd3:    begin ci = 3'd6; cj = 3'd7; end
            5'd4:    begin ci = 3'd0; cj = 3'd2; end
            5'd5:    begin ci = 3'd1; cj = 3'd3; end
            5'd6:    begin ci = 3'd4; cj = 3'd6; end
            5'd7:    begin ci = 3'd5; cj = 3'd7; end
            5'd8:    begin ci = 3'd1; cj = 3'd2; end
            5'd9:    begin ci = 3'd5; cj = 3'd6; end
            5'd10:   begin ci = 3'd0; cj = 3'd4; end
            5'd11:   begin ci = 3'd3; cj = 3'd7; end
            5'd12:   begin ci = 3'd1; cj = 3'd5; end
            5'd13:   begin ci = 3'd2; cj = 3'd6; end
            5'd14:   begin ci = 3'd1; cj = 3'd4; end
            5'd15:   begin ci = 3'd3; cj = 3'd6; end
            5'd16:   begin ci = 3'd2; cj = 3'd4; end
            5'd17:   begin ci = 3'd3; cj = 3'd5; end
            5'd18:   begin ci = 3'd3; cj = 3'd4; end
            default: begin ci = '0;   cj = '0;   end
        endcase
    end

    // Unsigned compare; equal values stay where they are
    assign swap      = regs[ci] < regs[cj];
    assign sort_done = step == STEP_W'(STEPS - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs, decoded from the current state
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        emit          = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = '0;
        bus.busy      = 1'b0;
        case (state)
            S_LOAD: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
                if (accept && wr_cnt == IDX_W'(N - 1)) begin
                    state_nxt = S_SORT;
                end
            end
            S_SORT: begin
                bus.busy = 1'b1;
                if (sort_done) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_data  = regs[rd_cnt];
                bus.out_last  = rd_cnt == IDX_W'(N - 1);
                emit          = bus.out_ready;
                if (emit && rd_cnt == IDX_W'(N - 1)) begin
                    state_nxt = S_LOAD;
                end
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    // Register file plus the load, step and drain counters.
    // Both counters wrap to 0 on their eighth increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
            step   <= '0;
            for (int k = 0; k < int'(N); k++) begin
                regs[k] <= '0;
            end
        end else begin
            if (accept) begin
                regs[wr_cnt] <= bus.in_data;
                wr_cnt       <= wr_cnt + IDX_W'(1);
            end
            if (state == S_SORT) begin
                if (swap) begin
                    regs[ci] <= regs[cj];
                    regs[cj] <= regs[ci];
                end
                step <= sort_done ? '0 : step + STEP_W'(1);
            end
            if (emit) begin
                rd_cnt <= rd_cnt + IDX_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_sort_sequencer.sv
// Directed and randomized checks of sort_sequencer against a plain descending-sort reference.
module tb_sort_sequencer;
    typedef logic [7:0] vec_t [8];

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    sort_sequencer_if #(.DATA_W(8)) bus ();

    sort_sequencer #(.DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: selection sort into descending order
    function automatic vec_t sort_desc(input vec_t d);
        vec_t r;
        logic [7:0] t;
        r = d;
        for (int a = 0; a < 8; a++) begin
            for (int b = a + 1; b < 8; b++) begin
                if (r[b] > r[a]) begin
                    t = r[a];
                    r[a] = r[b];
                    r[b] = t;
                end
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_last", 32'(bus.out_last), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
    endtask

    // Loads the first n words; with gaps, an idle cycle carrying junk data precedes each word
    task automatic load(input vec_t d, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                tick();
            end
            chk("load_in_ready", 32'(bus.in_ready), 1);
            bus.in_valid = 1'b1;
            bus.in_data  = d[i];
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    // Counts edges from the 8th accept until out_valid and drives junk in_valid meanwhile
    task automatic wait_sorted();
        int cnt;
        cnt = 0;
        chk("sort_busy", 32'(bus.busy), 1);
        chk("sort_in_ready", 32'(bus.in_ready), 0);
        while (!bus.out_valid && cnt < 100) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            tick();
            cnt++;
        end
        bus.in_valid = 1'b0;
        chk("latency", 32'(cnt), 19);
    endtask

    // Takes n outputs; with stalls, out_ready is held low for two cycles before each accept
    task automatic drain(input vec_t exp, input int n, input bit stalls);
        logic [7:0] held;
        logic       held_last;
        for (int k = 0; k < n; k++) begin
            chk("drain_valid", 32'(bus.out_valid), 1);
            if (stalls) begin
                held      = bus.out_data;
                held_last = bus.out_last;
                bus.out_ready = 1'b0;
                tick();
                tick();
                chk("stall_data", 32'(bus.out_data), 32'(held));
                chk("stall_last", 32'(bus.out_last), 32'(held_last));
            end
            chk("out_data", 32'(bus.out_data), 32'(exp[k]));
            chk("out_last", 32'(bus.out_last), (k == 7) ? 1 : 0);
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
        if (n == 8) begin
            chk("post_in_ready", 32'(bus.in_ready), 1);
            chk("post_out_valid", 32'(bus.out_valid), 0);
            chk("post_busy", 32'(bus.busy), 0);
        end
    endtask

    task automatic batch(input vec_t d, input bit gaps, input bit stalls);
        load(d, 8, gaps);
        wait_sorted();
        drain(sort_desc(d), 8, stalls);
    endtask

    initial begin
        vec_t d;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        do_reset();

        d = '{8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd5, 8'd4};
        batch(d, 1'b0, 1'b0);

        d = '{default: 8'h5A};
        batch(d, 1'b0, 1'b0);

        d = '{8'hFF, 8'h00, 8'h80, 8'h7F, 8'h01, 8'hFE, 8'h00, 8'hFF};
        batch(d, 1'b0, 1'b0);

        d = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        batch(d, 1'b1, 1'b1);

        // Reset mid-load, then a clean batch
        d = '{8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
        load(d, 5, 1'b0);
        do_reset();
        d = '{8'd40, 8'd10, 8'd30, 8'd20, 8'd70, 8'd50, 8'd80, 8'd60};
        batch(d, 1'b0, 1'b0);

        // Reset mid-drain, then a clean batch
        d = '{8'd200, 8'd100, 8'd150, 8'd250, 8'd0, 8'd50, 8'd75, 8'd25};
        load(d, 8, 1'b0);
        wait_sorted();
        drain(sort_desc(d), 2, 1'b0);
        do_reset();
        d = '{8'd4, 8'd4, 8'd9, 8'd1, 8'd0, 8'd7, 8'd9, 8'd3};
        batch(d, 1'b0, 1'b0);

        // Back-to-back batches
        d = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        batch(d, 1'b0, 1'b0);
        d = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        batch(d, 1'b0, 1'b0);

        // Random batches, half drawn from a narrow range to force duplicates
        for (int b = 0; b < 12; b++) begin
            for (int i = 0; i < 8; i++) begin
                d[i] = (b % 2 == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
            end
            batch(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
